alu_control_muldiv: RTL

Parametrised successor to the single-cycle ALU control decoder. Keeps the full ALU_OP/Funct → ALU_Instruction decode and adds the MIPS HI/LO unit: MULT/MULTU/DIV/DIVU run on an iterative radix-2 engine, one bit per cycle. MFHI/MFLO/MTHI/MTLO access the HI/LO registers. While an operation is in flight, a Stall output freezes PC and the pipeline registers in the datapath.

---
 rtl/alu_control_muldiv_pkg.sv | 53 +++++
 rtl/alu_control_muldiv_iter.sv | 80 ++++++++
 rtl/alu_control_muldiv.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_control_muldiv_pkg.sv
// Shared codes for the ALU control decoder and its HI/LO multiply/divide unit.
`default_nettype none
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_ANDI  = 3'b011;
  localparam logic [2:0] OP_ORI   = 3'b100;
  localparam logic [2:0] OP_SLTI  = 3'b101;
  localparam logic [2:0] OP_LUI   = 3'b110;
  localparam logic [2:0] OP_XORI  = 3'b111;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  localparam logic [3:0] A_AND       = 4'b0000;
  localparam logic [3:0] A_OR        = 4'b0001;
  localparam logic [3:0] A_ADD       = 4'b0010;
  localparam logic [3:0] A_SLL       = 4'b0100;
  localparam logic [3:0] A_SRA       = 4'b0101;
  localparam logic [3:0] A_SUB       = 4'b0110;
  localparam logic [3:0] A_SLT       = 4'b0111;
  localparam logic [3:0] A_SRL       = 4'b1000;
  localparam logic [3:0] A_LUI       = 4'b1001;
  localparam logic [3:0] A_PASS_HILO = 4'b1010;
  localparam logic [3:0] A_NOR       = 4'b1100;
  localparam logic [3:0] A_XOR       = 4'b1101;
  localparam logic [3:0] A_NOP       = 4'b1110;
  localparam logic [3:0] A_UNSUP     = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_control_muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider on operand magnitudes, with sign fix-up on the final step.
`default_nettype none
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic             r_active, r_div, r_neg_q, r_neg_r, r_dz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_m, r_hi, r_lo;

  logic             w_sa, w_sb, w_ge;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_nhi, w_nlo;
  logic [WIDTH:0]   w_sum, w_rsh, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_sa    = i_is_signed & i_a[WIDTH-1];
  assign w_sb    = i_is_signed & i_b[WIDTH-1];
  assign w_abs_a = w_sa ? -i_a : i_a;
  assign w_abs_b = w_sb ? -i_b : i_b;

  // Multiply: {r_hi,r_lo} holds partial product over the shifting multiplier.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_rsh - {1'b0, r_m};
  assign w_ge   = ~w_diff[WIDTH];

  assign w_nhi  = r_div ? (w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign w_nlo  = r_div ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_prod = r_neg_q ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};

  assign o_done = r_active && (r_cnt == c_last);
  assign o_hi   = r_div ? (r_neg_r ? -w_nhi : w_nhi) : w_prod[2*WIDTH-1:WIDTH];
  assign o_lo   = r_div ? ((r_neg_q && !r_dz) ? -w_nlo : w_nlo) : w_prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_div    <= i_is_div;
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_dz     <= i_is_div && (i_b == '0);
      r_cnt    <= '0;
      r_m      <= i_is_div ? w_abs_b : w_abs_a;
      r_hi     <= '0;
      r_lo     <= i_is_div ? w_abs_a : w_abs_b;
    end else if (r_active) begin
      r_hi     <= w_nhi;
      r_lo     <= w_nlo;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) r_active <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_muldiv.sv
// ALU control decoder with a HI/LO multiply/divide unit that stalls the pipeline while iterating.
`default_nettype none
module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ALU_OP_W = 3,
  parameter int FUNCT_W  = 6,
  parameter int CTRL_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ALU_OP_W-1:0] ALU_OP_D,
  input  logic [FUNCT_W-1:0]  Funct,
  input  logic [WIDTH-1:0]    SrcA,
  input  logic [WIDTH-1:0]    SrcB,
  output logic [CTRL_W-1:0]   ALU_Instruction,
  output logic                Stall,
  output logic [WIDTH-1:0]    HiLo_Out,
  output logic                Busy
);

  logic [1:0]       r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_rtype, w_is_md, w_start, w_done;
  logic [3:0]       w_code;
  logic [WIDTH-1:0] w_eng_hi, w_eng_lo;

  assign w_rtype = (ALU_OP_D == ALU_OP_W'(OP_RTYPE));
  assign w_is_md = w_rtype && (Funct == FUNCT_W'(F_MULT)  || Funct == FUNCT_W'(F_MULTU) ||
                               Funct == FUNCT_W'(F_DIV)   || Funct == FUNCT_W'(F_DIVU));
  // Gated by rst_n so a held mul/div instruction cannot raise Stall while in reset.
  assign w_start = rst_n && (r_state == S_IDLE) && w_is_md;

  always_comb begin
    w_code = A_UNSUP;
    case (ALU_OP_D)
      ALU_OP_W'(OP_ADD):  w_code = A_ADD;
      ALU_OP_W'(OP_SUB):  w_code = A_SUB;
      ALU_OP_W'(OP_ANDI): w_code = A_AND;
      ALU_OP_W'(OP_ORI):  w_code = A_OR;
      ALU_OP_W'(OP_SLTI): w_code = A_SLT;
      ALU_OP_W'(OP_LUI):  w_code = A_LUI;
      ALU_OP_W'(OP_XORI): w_code = A_XOR;
      ALU_OP_W'(OP_RTYPE): begin
        case (Funct)
          FUNCT_W'(F_ADD):   w_code = A_ADD;
          FUNCT_W'(F_SUB):   w_code = A_SUB;
          FUNCT_W'(F_AND):   w_code = A_AND;
          FUNCT_W'(F_OR):    w_code = A_OR;
          FUNCT_W'(F_NOR):   w_code = A_NOR;
          FUNCT_W'(F_XOR):   w_code = A_XOR;
          FUNCT_W'(F_SLL):   w_code = A_SLL;
          FUNCT_W'(F_SLT):   w_code = A_SLT;
          FUNCT_W'(F_SRA):   w_code = A_SRA;
          FUNCT_W'(F_SRL):   w_code = A_SRL;
          FUNCT_W'(F_MULT), FUNCT_W'(F_MULTU),
          FUNCT_W'(F_DIV),  FUNCT_W'(F_DIVU),
          FUNCT_W'(F_MTHI), FUNCT_W'(F_MTLO): w_code = A_NOP;
          FUNCT_W'(F_MFHI), FUNCT_W'(F_MFLO): w_code = A_PASS_HILO;
          default:           w_code = A_UNSUP;
        endcase
      end
      default: w_code = A_UNSUP;
    endcase
  end

  assign ALU_Instruction = CTRL_W'(w_code);
  assign Stall    = w_start || (r_state == S_RUN);
  assign Busy     = r_busy;
  assign HiLo_Out = (w_rtype && Funct == FUNCT_W'(F_MFHI)) ? r_hi :
                    (w_rtype && Funct == FUNCT_W'(F_MFLO)) ? r_lo : '0;

  muldiv_iter #(.WIDTH(WIDTH)) u_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start),
    .i_is_div    (Funct[1]),
    .i_is_signed (~Funct[0]),
    .i_a         (SrcA),
    .i_b         (SrcB),
    .o_done      (w_done),
    .o_hi        (w_eng_hi),
    .o_lo        (w_eng_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else if (w_rtype && Funct == FUNCT_W'(F_MTHI)) begin
            r_hi <= SrcA;
          end else if (w_rtype && Funct == FUNCT_W'(F_MTLO)) begin
            r_lo <= SrcA;
          end
        end
        S_RUN: begin
          if (w_done) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_hi    <= w_eng_hi;
            r_lo    <= w_eng_lo;
          end
        end
        // The retiring mul/div is still presented here; it must not restart the engine.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
